// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts PC-stage fetches, reads the program RAM through a
// LATENCY-deep pipe and returns in-order responses through a credit-controlled queue.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = LATENCY + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic out_of_range(input logic [29:0] word);
    return {2'b00, word} >= 32'(DEPTH_WORDS);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept_p0;
  logic          fault_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0]   instr_p0;

  logic          push;
  logic [31:0]   src_instr;
  logic [31:0]   src_addr;
  logic          src_fault;
  logic          pop;

  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_addr  [QDEPTH];
  logic          q_fault [QDEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] q_cnt;
  logic [CW-1:0] cnt;

  logic          unused_wr_lo;
  assign unused_wr_lo = ^wr_addr[1:0];

  // Stage p0: accept cycle, combinational RAM read sees pre-write contents
  assign accept_p0 = req_valid && req_ready;
  assign fault_p0  = (req_addr[1:0] != 2'b00) || out_of_range(req_addr[31:2]);
  assign idx_p0    = req_addr[AW+1:2];
  assign instr_p0  = fault_p0 ? NOP : mem[idx_p0];

  always_ff @(posedge clk) begin
    if (wr_en && !out_of_range(wr_addr[31:2])) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int PS = LATENCY - 1;
      logic        vld_pn   [PS];
      logic [31:0] instr_pn [PS];
      logic [31:0] addr_pn  [PS];
      logic        fault_pn [PS];

      // Stages p1..p(LATENCY-1): the newest entry survives a flush, older ones do not
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < PS; k++) vld_pn[k] <= 1'b0;
        end else begin
          vld_pn[0] <= accept_p0;
          for (int k = 1; k < PS; k++) vld_pn[k] <= vld_pn[k-1] && !flush;
        end
      end

      always_ff @(posedge clk) begin
        instr_pn[0] <= instr_p0;
        addr_pn[0]  <= req_addr;
        fault_pn[0] <= fault_p0;
        for (int k = 1; k < PS; k++) begin
          instr_pn[k] <= instr_pn[k-1];
          addr_pn[k]  <= addr_pn[k-1];
          fault_pn[k] <= fault_pn[k-1];
        end
      end

      assign push      = vld_pn[PS-1] && !flush;
      assign src_instr = instr_pn[PS-1];
      assign src_addr  = addr_pn[PS-1];
      assign src_fault = fault_pn[PS-1];
    end else begin : g_direct
      assign push      = accept_p0;
      assign src_instr = instr_p0;
      assign src_addr  = req_addr;
      assign src_fault = fault_p0;
    end
  endgenerate

  // Response queue: flush discards everything queued but keeps this cycle's push
  assign pop = resp_valid && resp_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      q_cnt <= '0;
      cnt   <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (flush) begin
        rptr  <= wptr;
        q_cnt <= CW'(push);
        cnt   <= CW'(accept_p0);
      end else begin
        if (pop) rptr <= next_ptr(rptr);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
        cnt   <= cnt + CW'(accept_p0) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wptr] <= src_instr;
      q_addr[wptr]  <= src_addr;
      q_fault[wptr] <= src_fault;
    end
  end

  assign req_ready  = cnt < CW'(QDEPTH);
  assign resp_valid = q_cnt != '0;
  assign resp_instr = resp_valid ? q_instr[rptr] : '0;
  assign resp_addr  = resp_valid ? q_addr[rptr]  : '0;
  assign resp_fault = resp_valid && q_fault[rptr];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios followed by randomized traffic,
// checked against a word-array reference model of the instruction memory.
module tb_imem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int QDEPTH      = LATENCY + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_fault;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  imem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH_WORDS];
  int          n_checks = 0;
  int          n_pass = 0;
  int          model_out = 0;
  bit          started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.addr  = a;
    e.fault = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH_WORDS));
    e.instr = e.fault ? NOP : ref_mem[int'(a >> 2)];
    return e;
  endfunction

  // Stimulus side: predicts every accepted request and tracks outstanding credits
  always @(negedge clk) begin : issue_side
    bit acc, pop;
    if (!rst_n) begin
      exp_q.delete();
      model_out = 0;
      started = 1;
    end else if (started) begin
      check("req_ready_credit", 32'(req_ready), 32'(model_out < QDEPTH));
      acc = req_valid && req_ready;
      pop = resp_valid && resp_ready && !flush;
      if (flush) begin
        exp_q.delete();
        model_out = int'(acc);
      end else begin
        model_out = model_out + int'(acc) - int'(pop);
      end
      if (acc) exp_q.push_back(model(req_addr));
    end
    if (wr_en && ((wr_addr >> 2) < 32'(DEPTH_WORDS))) ref_mem[int'(wr_addr >> 2)] = wr_data;
  end

  logic        hold_pending = 1'b0;
  logic [31:0] hold_addr, hold_instr;
  logic        hold_fault;

  // Response side: pops the scoreboard on every consumed response
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n || !started) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_addr", resp_addr, hold_addr);
        check("hold_instr", resp_instr, hold_instr);
        check("hold_fault", 32'(resp_fault), 32'(hold_fault));
      end
      if (resp_valid && resp_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_addr", resp_addr, e.addr);
          check("resp_instr", resp_instr, e.instr);
          check("resp_fault", 32'(resp_fault), 32'(e.fault));
        end
      end
      hold_pending = resp_valid && !resp_ready && !flush;
      hold_addr    = resp_addr;
      hold_instr   = resp_instr;
      hold_fault   = resp_fault;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lat_req(input logic [31:0] a, input string name);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    check(name, 32'(n), 32'(LATENCY));
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int acc_cnt;
    int r;
    // Reset and reset-state outputs
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_instr", resp_instr, 32'd0);
    check("rst_resp_addr", resp_addr, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Program preload: words 0..3 fixed, 4..63 random
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_addr = 32'(4 * i);
      wr_data = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
      tick();
    end
    wr_en = 1'b0;
    resp_ready = 1'b1;

    // Back-to-back burst with full throughput
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * i);
      @(negedge clk);
      check("burst_req_ready", 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    idle(6);
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    lat_req(32'h0000_0008, "latency_read");

    // Back-pressure: exactly QDEPTH accepts, head held
    resp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * i);
      @(negedge clk);
      if (req_valid && req_ready) acc_cnt++;
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 32'(acc_cnt), 32'(QDEPTH));
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_head_addr", resp_addr, 32'h0);
    check("bp_head_instr", resp_instr, 32'h11);
    tick();
    resp_ready = 1'b1;
    idle(8);
    @(negedge clk);
    check("bp_ready_back", 32'(req_ready), 32'd1);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Faults at normal latency
    lat_req(32'h0000_0002, "latency_misaligned");
    lat_req(32'h0000_1000, "latency_out_of_range");

    // Flush with a surviving redirect request
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_addr  = 32'h4;
    tick();
    flush     = 1'b1;
    req_addr  = 32'h8;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_gap", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("flush_target_valid", 32'(resp_valid), 32'd1);
    check("flush_target_addr", resp_addr, 32'h8);
    check("flush_target_instr", resp_instr, 32'h33);
    tick();
    idle(3);

    // Read-before-write, then an ignored out-of-range write
    req_valid = 1'b1;
    req_addr  = 32'h4;
    wr_en     = 1'b1;
    wr_addr   = 32'h4;
    wr_data   = 32'h0000_DEAD;
    tick();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    idle(4);
    wr_en   = 1'b1;
    wr_addr = 32'(DEPTH_WORDS * 4 + 4);
    wr_data = 32'h0000_0BAD;
    tick();
    wr_en = 1'b0;
    lat_req(32'h4, "latency_after_write");
    idle(2);

    // Reset with queued responses
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    idle(4);
    @(negedge clk);
    check("pre_reset_queued", 32'(resp_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    tick();
    resp_ready = 1'b1;
    idle(3);
    lat_req(32'h0, "latency_after_reset");
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 19));
      if (r < 2)       req_addr = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      else if (r == 2) req_addr = 32'(DEPTH_WORDS * 4 + 4 * $urandom_range(0, 255));
      else             req_addr = 32'(4 * $urandom_range(0, 63));
      resp_ready = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 29) == 0);
      wr_en      = ($urandom_range(0, 9) == 0);
      wr_addr    = ($urandom_range(0, 7) == 0) ? 32'(DEPTH_WORDS * 4 + 4 * $urandom_range(0, 63))
                                               : 32'(4 * $urandom_range(0, 63));
      wr_data    = $urandom;
      tick();
    end
    req_valid  = 1'b0;
    flush      = 1'b0;
    wr_en      = 1'b0;
    resp_ready = 1'b1;
    idle(20);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
